multi_line_raster: RTL and testbench

//  Parametrised successor to the single-line scanline renderer: draws NUM_LINES arbitrary

---
 rtl/mlr_pkg.sv | 16 +
 rtl/scanline_buffer.sv | 31 +++
 rtl/multi_line_raster.sv | 253 +++++++++++++++++++++++++
 tb/tb_multi_line_raster.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mlr_pkg.sv
// Shared types and helpers for the multi-line scanline rasteriser.
package mlr_pkg;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_IDLE  = 2'd1,
        ST_DRAW  = 2'd2,
        ST_COPY  = 2'd3
    } state_t;

    // Bresenham error term width: wide enough for 2*err against +dx / -dy
    function automatic int err_w(input int xw, input int yw);
        return ((xw > yw) ? xw : yw) + 2;
    endfunction

endpackage

// File: rtl/scanline_buffer.sv
// One-scanline pixel store. Port A reads and erases in the same cycle
// (read-first), port B writes. Read data appears one cycle after the enable.
module scanline_buffer #(
    parameter int DEPTH = 640,
    parameter int AW    = 10,
    parameter int PW    = 16
) (
    input  logic          clk,
    input  logic          a_en,
    input  logic [AW-1:0] a_addr,
    input  logic [PW-1:0] a_wdata,
    output logic [PW-1:0] a_rdata,
    input  logic          b_we,
    input  logic [AW-1:0] b_addr,
    input  logic [PW-1:0] b_wdata
);

    logic [PW-1:0] mem [DEPTH];

    // Read-first erase on A, plain write on B; the two never share an address
    always_ff @(posedge clk) begin
        if (a_en) begin
            a_rdata      <= mem[a_addr];
            mem[a_addr]  <= a_wdata;
        end
        if (b_we) begin
            mem[b_addr] <= b_wdata;
        end
    end

endmodule

// File: rtl/multi_line_raster.sv
// Renders NUM_LINES Bresenham lines over a background one scanline at a time
// and streams each finished scanline to the video FIFO.
module multi_line_raster
    import mlr_pkg::*;
#(
    parameter int H_RES     = 640,
    parameter int V_RES     = 480,
    parameter int NUM_LINES = 4,
    parameter int XW        = 10,
    parameter int YW        = 10,
    parameter int PW        = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    trigger,
    input  logic [NUM_LINES*XW-1:0] x0,
    input  logic [NUM_LINES*XW-1:0] x1,
    input  logic [NUM_LINES*YW-1:0] y0,
    input  logic [NUM_LINES*YW-1:0] y1,
    input  logic [NUM_LINES*PW-1:0] color,
    input  logic [PW-1:0]           bg_color,
    input  logic                    fifo_full,
    output logic                    fifo_write,
    output logic [PW-1:0]           fifo_data,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int EW = err_w(XW, YW);
    localparam int AW = (H_RES > 1) ? $clog2(H_RES) : 1;
    localparam int CW = $clog2(H_RES + 1);
    localparam int LW = (NUM_LINES > 1) ? $clog2(NUM_LINES) : 1;

    localparam logic [CW-1:0] H_LAST  = CW'(H_RES - 1);
    localparam logic [CW-1:0] H_END   = CW'(H_RES);
    localparam logic [XW:0]   H_RES_X = (XW+1)'(H_RES);
    localparam logic [YW-1:0] V_LAST  = YW'(V_RES - 1);
    localparam logic [LW-1:0] L_LAST  = LW'(NUM_LINES - 1);

    state_t state, state_nxt;

    logic [CW-1:0] cnt;       // CLEAR write address / COPY read-issue address
    logic [CW-1:0] out_x;     // pixels pushed on the current scanline
    logic          rd_vld;    // buffer read data waiting to be pushed
    logic [YW-1:0] scanline;
    logic [LW-1:0] li;        // line being visited in DRAW
    logic [PW-1:0] bg_q;

    // Per-line Bresenham state
    logic [XW-1:0]        cx_q   [NUM_LINES];
    logic [XW-1:0]        ex_q   [NUM_LINES];
    logic [YW-1:0]        cy_q   [NUM_LINES];
    logic [YW-1:0]        ey_q   [NUM_LINES];
    logic signed [EW-1:0] err_q  [NUM_LINES];
    logic signed [EW-1:0] dx_q   [NUM_LINES];
    logic signed [EW-1:0] dy_q   [NUM_LINES];
    logic                 sxn_q  [NUM_LINES];
    logic                 fin_q  [NUM_LINES];
    logic [PW-1:0]        col_q  [NUM_LINES];

    // Endpoints normalised so y always rises
    logic [XW-1:0]        nx0 [NUM_LINES];
    logic [XW-1:0]        nx1 [NUM_LINES];
    logic [YW-1:0]        ny0 [NUM_LINES];
    logic [YW-1:0]        ny1 [NUM_LINES];
    logic signed [EW-1:0] ndx [NUM_LINES];
    logic signed [EW-1:0] ndy [NUM_LINES];

    logic                 on_line, at_end, step_x, step_y, line_adv, plot_ok;
    logic signed [EW:0]   e2, dx_w, dy_w;
    logic signed [EW-1:0] err_nxt;

    logic          trig_acc, push, slot_free, issue, last_push;
    logic [PW-1:0] rd_data;
    logic          b_we;
    logic [AW-1:0] b_addr;
    logic [PW-1:0] b_wdata;

    assign trig_acc  = (state == ST_IDLE) && trigger;
    assign push      = rd_vld && !fifo_full;
    assign slot_free = !rd_vld || !fifo_full;
    assign issue     = (state == ST_COPY) && (cnt != H_END) && slot_free;
    assign last_push = push && (out_x == H_LAST);

    // Swap endpoints of downward lines and derive the Bresenham constants
    always_comb begin
        for (int i = 0; i < NUM_LINES; i++) begin
            if (y1[i*YW +: YW] < y0[i*YW +: YW]) begin
                nx0[i] = x1[i*XW +: XW];
                ny0[i] = y1[i*YW +: YW];
                nx1[i] = x0[i*XW +: XW];
                ny1[i] = y0[i*YW +: YW];
            end else begin
                nx0[i] = x0[i*XW +: XW];
                ny0[i] = y0[i*YW +: YW];
                nx1[i] = x1[i*XW +: XW];
                ny1[i] = y1[i*YW +: YW];
            end
            ndx[i] = (nx1[i] >= nx0[i]) ? $signed(EW'(nx1[i] - nx0[i]))
                                        : $signed(EW'(nx0[i] - nx1[i]));
            ndy[i] = $signed(EW'(ny1[i] - ny0[i]));
        end
    end

    // One Bresenham step for the line currently visited
    always_comb begin
        on_line = (cy_q[li] == scanline) && !fin_q[li];
        at_end  = (cx_q[li] == ex_q[li]) && (cy_q[li] == ey_q[li]);
        e2      = {err_q[li], 1'b0};
        dx_w    = {dx_q[li][EW-1], dx_q[li]};
        dy_w    = {dy_q[li][EW-1], dy_q[li]};
        step_x  = (e2 >= -dy_w);
        step_y  = (e2 <= dx_w);
        err_nxt = err_q[li];
        if (step_x) err_nxt = err_nxt - dy_q[li];
        if (step_y) err_nxt = err_nxt + dx_q[li];
        line_adv = !on_line || at_end || step_y;
        plot_ok  = on_line && ({1'b0, cx_q[li]} < H_RES_X);
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_CLEAR;
        else        state <= state_nxt;
    end

    // FSM next-state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_CLEAR: if (cnt == H_LAST) state_nxt = ST_IDLE;
            ST_IDLE:  if (trigger) state_nxt = ST_DRAW;
            ST_DRAW:  if (line_adv && li == L_LAST) state_nxt = ST_COPY;
            ST_COPY:  if (last_push) state_nxt = (scanline == V_LAST) ? ST_IDLE : ST_DRAW;
            default:  state_nxt = ST_CLEAR;
        endcase
    end

    // FSM outputs and buffer write port
    always_comb begin
        busy       = (state != ST_IDLE);
        fifo_write = push;
        fifo_data  = push ? rd_data : '0;
        b_we       = 1'b0;
        b_addr     = '0;
        b_wdata    = bg_color;
        case (state)
            ST_CLEAR: begin
                b_we    = 1'b1;
                b_addr  = cnt[AW-1:0];
                b_wdata = bg_color;
            end
            ST_DRAW: begin
                b_we    = plot_ok;
                b_addr  = cx_q[li][AW-1:0];
                b_wdata = col_q[li];
            end
            default: ;
        endcase
    end

    // Counters, scanline/line sequencing, COPY pipeline and frame_done
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt        <= '0;
            out_x      <= '0;
            rd_vld     <= 1'b0;
            scanline   <= '0;
            li         <= '0;
            bg_q       <= '0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= last_push && (scanline == V_LAST);
            if (slot_free) rd_vld <= issue;
            if (push) out_x <= last_push ? '0 : out_x + 1'b1;
            case (state)
                ST_CLEAR: cnt <= (cnt == H_LAST) ? '0 : cnt + 1'b1;
                ST_IDLE: begin
                    cnt <= '0;
                    if (trigger) begin
                        bg_q     <= bg_color;
                        scanline <= '0;
                        li       <= '0;
                    end
                end
                ST_DRAW: if (line_adv) li <= (li == L_LAST) ? '0 : li + 1'b1;
                ST_COPY: begin
                    if (issue) cnt <= cnt + 1'b1;
                    if (last_push) begin
                        cnt      <= '0;
                        scanline <= scanline + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Per-line state: latch on trigger, advance one pixel per DRAW cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                cx_q[i]  <= '0;
                ex_q[i]  <= '0;
                cy_q[i]  <= '0;
                ey_q[i]  <= '0;
                err_q[i] <= '0;
                dx_q[i]  <= '0;
                dy_q[i]  <= '0;
                sxn_q[i] <= 1'b0;
                fin_q[i] <= 1'b1;
                col_q[i] <= '0;
            end
        end else if (trig_acc) begin
            for (int i = 0; i < NUM_LINES; i++) begin
                cx_q[i]  <= nx0[i];
                ex_q[i]  <= nx1[i];
                cy_q[i]  <= ny0[i];
                ey_q[i]  <= ny1[i];
                dx_q[i]  <= ndx[i];
                dy_q[i]  <= ndy[i];
                err_q[i] <= ndx[i] - ndy[i];
                sxn_q[i] <= (nx1[i] < nx0[i]);
                fin_q[i] <= 1'b0;
                col_q[i] <= color[i*PW +: PW];
            end
        end else if (state == ST_DRAW && on_line) begin
            if (at_end) begin
                fin_q[li] <= 1'b1;
            end else begin
                err_q[li] <= err_nxt;
                if (step_x) cx_q[li] <= sxn_q[li] ? cx_q[li] - 1'b1 : cx_q[li] + 1'b1;
                if (step_y) cy_q[li] <= cy_q[li] + 1'b1;
            end
        end
    end

    scanline_buffer #(
        .DEPTH (H_RES),
        .AW    (AW),
        .PW    (PW)
    ) u_buf (
        .clk     (clk),
        .a_en    (issue),
        .a_addr  (cnt[AW-1:0]),
        .a_wdata (bg_q),
        .a_rdata (rd_data),
        .b_we    (b_we),
        .b_addr  (b_addr),
        .b_wdata (b_wdata)
    );

endmodule

// File: tb/tb_multi_line_raster.sv
// Directed bench for multi_line_raster on a 16x8 screen with two lines.
module tb_multi_line_raster;

    localparam int H = 16, V = 8, NL = 2, XW = 5, YW = 4, PW = 8;
    localparam int NPIX = H * V;

    logic              clk = 1'b0, rst_n = 1'b0, trigger = 1'b0;
    logic [NL*XW-1:0]  x0 = '0, x1 = '0;
    logic [NL*YW-1:0]  y0 = '0, y1 = '0;
    logic [NL*PW-1:0]  color = '0;
    logic [PW-1:0]     bg_color = '0;
    logic              fifo_full = 1'b0;
    logic              stall_en = 1'b0;
    logic              fifo_write, busy, frame_done;
    logic [PW-1:0]     fifo_data;

    int checks = 0, errors = 0;

    // Captured stream (written only by the monitor)
    logic [PW-1:0] pix [0:2047];
    int pix_n = 0, fd_n = 0, fd_at = 0, push_full = 0;

    logic [PW-1:0] exp_px [0:NPIX-1];

    multi_line_raster #(
        .H_RES(H), .V_RES(V), .NUM_LINES(NL), .XW(XW), .YW(YW), .PW(PW)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .trigger    (trigger),
        .x0         (x0),
        .x1         (x1),
        .y0         (y0),
        .y1         (y1),
        .color      (color),
        .bg_color   (bg_color),
        .fifo_full  (fifo_full),
        .fifo_write (fifo_write),
        .fifo_data  (fifo_data),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Random back-pressure when enabled
    always @(posedge clk) begin
        #1;
        fifo_full = stall_en ? ($urandom_range(0, 1) == 1) : 1'b0;
    end

    // Push / frame_done monitor
    always @(negedge clk) begin
        if (fifo_write) begin
            if (fifo_full) push_full++;
            if (pix_n < 2048) pix[pix_n] = fifo_data;
            pix_n++;
        end
        if (frame_done) begin
            fd_n++;
            fd_at = pix_n;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic set_lines(input int ax0, input int ay0, input int ax1, input int ay1, input int ac,
                             input int bx0, input int by0, input int bx1, input int by1, input int bc);
        x0    = {XW'(bx0), XW'(ax0)};
        y0    = {YW'(by0), YW'(ay0)};
        x1    = {XW'(bx1), XW'(ax1)};
        y1    = {YW'(by1), YW'(ay1)};
        color = {PW'(bc), PW'(ac)};
    endtask

    task automatic exp_clear();
        for (int k = 0; k < NPIX; k++) exp_px[k] = '0;
    endtask

    task automatic exp_set(input int row, input int x, input int v);
        exp_px[row*H + x] = PW'(v);
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (busy && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        check({tag, "_idle"}, 32'(busy), 0);
    endtask

    task automatic pulse_trigger();
        trigger = 1'b1;
        @(posedge clk); #1;
        trigger = 1'b0;
    endtask

    task automatic run_frame(input string tag, output int base);
        int n, fd0;
        wait_idle(tag);
        base = pix_n;
        fd0  = fd_n;
        pulse_trigger();
        n = 0;
        while (fd_n == fd0 && n < 4000) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_timeout"}, 32'(fd_n == fd0), 0);
        repeat (3) @(negedge clk);
        check({tag, "_pushes"}, pix_n - base, NPIX);
        check({tag, "_done_cnt"}, fd_n - fd0, 1);
        check({tag, "_done_at"}, fd_at - base, NPIX);
    endtask

    task automatic cmp_frame(input string tag, input int base);
        int bad, first;
        bad = 0; first = -1;
        for (int k = 0; k < NPIX; k++) begin
            if (pix[base+k] !== exp_px[k]) begin
                bad++;
                if (first < 0) first = k;
            end
        end
        if (bad != 0)
            $display("  %s first differing pixel index %0d data %0h want %0h",
                     tag, first, pix[base+first], exp_px[first]);
        check({tag, "_pixels"}, bad, 0);
    endtask

    task automatic count_clear(input string tag);
        int n;
        n = 0;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            n++;
            if (!busy) break;
        end
        check({tag, "_clear_cycles"}, n, H);
    endtask

    initial begin
        int b_a, b_b, b_c, b_d1, b_d2, b_e, b_r, p0, n, bad;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_fifo_write", 32'(fifo_write), 0);
        check("rst_fifo_data",  32'(fifo_data), 0);
        check("rst_frame_done", 32'(frame_done), 0);
        check("rst_busy",       32'(busy), 1);
        @(negedge clk);
        rst_n = 1'b1;
        check("rel_busy", 32'(busy), 1);
        count_clear("rel");
        repeat (5) @(posedge clk);
        #1;
        check("idle_no_push", pix_n, 0);
        check("idle_busy", 32'(busy), 0);

        // A: shallow line across the screen, second line below the screen
        set_lines(0, 0, 15, 3, 8'hAA, 2, 12, 9, 12, 8'h55);
        run_frame("A", b_a);
        exp_clear();
        for (int x = 0;  x <= 2;  x++) exp_set(0, x, 8'hAA);
        for (int x = 3;  x <= 7;  x++) exp_set(1, x, 8'hAA);
        for (int x = 8;  x <= 12; x++) exp_set(2, x, 8'hAA);
        for (int x = 13; x <= 15; x++) exp_set(3, x, 8'hAA);
        cmp_frame("A", b_a);
        check("A_r1x3", 32'(pix[b_a + 1*H + 3]), 32'h0AA);
        check("A_r4x0", 32'(pix[b_a + 4*H + 0]), 32'h000);

        // B: reversed vertical line; second line entirely right of the screen
        set_lines(5, 7, 5, 0, 8'hAA, 20, 3, 28, 3, 8'h77);
        run_frame("B", b_b);
        exp_clear();
        for (int r = 0; r < V; r++) exp_set(r, 5, 8'hAA);
        cmp_frame("B", b_b);
        check("B_r7x5", 32'(pix[b_b + 7*H + 5]), 32'h0AA);

        // C: horizontal line overdrawn by a later vertical line
        set_lines(0, 2, 15, 2, 8'h11, 3, 0, 3, 7, 8'h22);
        run_frame("C", b_c);
        exp_clear();
        for (int x = 0; x < H; x++) exp_set(2, x, 8'h11);
        for (int r = 0; r < V; r++) exp_set(r, 3, 8'h22);
        cmp_frame("C", b_c);
        check("C_r2x3", 32'(pix[b_c + 2*H + 3]), 32'h022);
        check("C_r2x4", 32'(pix[b_c + 2*H + 4]), 32'h011);

        // D: same scene unstalled and then with random back-pressure
        set_lines(0, 0, 15, 3, 8'hAA, 9, 6, 9, 6, 8'h33);
        run_frame("D1", b_d1);
        stall_en = 1'b1;
        run_frame("D2", b_d2);
        stall_en = 1'b0;
        exp_clear();
        for (int x = 0;  x <= 2;  x++) exp_set(0, x, 8'hAA);
        for (int x = 3;  x <= 7;  x++) exp_set(1, x, 8'hAA);
        for (int x = 8;  x <= 12; x++) exp_set(2, x, 8'hAA);
        for (int x = 13; x <= 15; x++) exp_set(3, x, 8'hAA);
        exp_set(6, 9, 8'h33);
        cmp_frame("D1", b_d1);
        cmp_frame("D2", b_d2);
        bad = 0;
        for (int k = 0; k < NPIX; k++) if (pix[b_d1+k] !== pix[b_d2+k]) bad++;
        check("D_stream_equal", bad, 0);
        check("D_no_push_when_full", push_full, 0);

        // Reset during COPY of scanline 1, with undrawn/unerased data left in the buffer
        set_lines(0, 2, 15, 2, 8'h11, 3, 0, 3, 7, 8'h22);
        wait_idle("R");
        b_r = pix_n;
        pulse_trigger();
        n = 0;
        while (pix_n < b_r + H + 2 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("R_reach_copy", 32'(pix_n >= b_r + H + 2), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("R_rst_fifo_write", 32'(fifo_write), 0);
        check("R_rst_busy", 32'(busy), 1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        count_clear("R");
        p0 = pix_n;
        repeat (20) @(posedge clk);
        #1;
        check("R_no_push_after_reset", pix_n - p0, 0);

        // E: single point; nothing stale from the aborted frame may appear
        set_lines(12, 5, 12, 5, 8'h44, 0, 15, 3, 15, 8'h99);
        run_frame("E", b_e);
        exp_clear();
        exp_set(5, 12, 8'h44);
        cmp_frame("E", b_e);
        check("E_r5x12", 32'(pix[b_e + 5*H + 12]), 32'h044);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
